// File: rtl/stage_reg_skid.sv
// +--------------------------------------------------------------------------+
// | stage_reg_skid: pipeline stage register, one-entry skid, flush, ctrl mask |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module stage_reg_skid #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
  logic              w_acc;
  logic              w_drain;

  // in_ready depends only on state and reset, never on out_ready.
  assign in_ready  = reset_n & ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  assign w_acc   = in_valid & in_ready & ~flush;
  assign w_drain = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_ctrl_d  = main_ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      // Data registers intentionally hold; only valid and ctrl are killed.
      main_valid_d = 1'b0;
      main_ctrl_d  = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (skid_valid_q) begin
      if (w_drain) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_ctrl_d  = skid_ctrl_q;
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end
    end else if (!main_valid_q || w_drain) begin
      if (w_acc) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_ctrl_d  = in_ctrl;
      end else if (main_valid_q) begin
        main_valid_d = 1'b0;
        main_ctrl_d  = '0;
      end
    end else if (w_acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_ctrl_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stage_reg_skid.sv
// +--------------------------------------------------------------------------+
// | tb_stage_reg_skid: directed and random checks for stage_reg_skid         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_stage_reg_skid;

  localparam int C_DW = 69;
  localparam int C_CW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [C_DW-1:0] in_data;
  logic [C_CW-1:0] in_ctrl;
  logic            out_valid;
  logic            out_ready;
  logic [C_DW-1:0] out_data;
  logic [C_CW-1:0] out_ctrl;
  logic [1:0]      occupancy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [C_DW-1:0] d;
    logic [C_CW-1:0] c;
  } entry_t;

  stage_reg_skid #(.DATA_W(C_DW), .CTRL_W(C_CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 4'hF;
    in_data = C_DW'(69'h1234); out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      total++; if (out_ctrl !== 4'h0) begin bad++; $display("FAIL rst_out_ctrl got=%h exp=0", out_ctrl); end
      total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    end
    reset_n = 1'b1; in_valid = 1'b0; in_ctrl = 4'h0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid got=%b exp=0", out_valid); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rel_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_data = C_DW'(i); in_ctrl = 4'b0101;
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (out_data !== C_DW'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%0h exp=%0h", i, out_data, i); end
      total++; if (out_ctrl !== 4'b0101) begin bad++; $display("FAIL stream_ctrl[%0d] got=%h exp=5", i, out_ctrl); end
      total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = C_DW'(8'hA); in_ctrl = 4'hA;
    tick();
    total++; if (out_data !== C_DW'(8'hA) || occupancy !== 2'd1) begin bad++; $display("FAIL stall_a got=%0h/%0d exp=a/1", out_data, occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_a_ready got=%b exp=1", in_ready); end
    in_data = C_DW'(8'hB); in_ctrl = 4'hB;
    tick();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL stall_b_occ got=%0d exp=2", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_b_ready got=%b exp=0", in_ready); end
    total++; if (out_data !== C_DW'(8'hA) || out_ctrl !== 4'hA) begin bad++; $display("FAIL stall_b_out got=%0h/%h exp=a/a", out_data, out_ctrl); end
    in_data = C_DW'(8'hC); in_ctrl = 4'hC;
    tick();
    total++; if (occupancy !== 2'd2 || out_data !== C_DW'(8'hA)) begin bad++; $display("FAIL stall_c_blocked got=%0d/%0h exp=2/a", occupancy, out_data); end
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== C_DW'(8'hB) || out_ctrl !== 4'hB) begin bad++; $display("FAIL recover_b got=%0h/%h exp=b/b", out_data, out_ctrl); end
    total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL recover_ready got=%0d/%b exp=1/1", occupancy, in_ready); end
    tick();
    total++; if (out_data !== C_DW'(8'hC) || out_valid !== 1'b1) begin bad++; $display("FAIL recover_c got=%0h/%b exp=c/1", out_data, out_valid); end
    in_valid = 1'b0;
    tick();
    total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL recover_empty got=%0d/%b exp=0/0", occupancy, out_valid); end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = C_DW'(1); in_ctrl = 4'h3; tick();
    in_data = C_DW'(2); in_ctrl = 4'h6; tick();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = C_DW'(8'hD); in_ctrl = 4'hF;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin bad++; $display("FAIL flush_out got=%b/%h exp=0/0", out_valid, out_ctrl); end
    total++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_occ got=%0d/%b exp=0/1", occupancy, in_ready); end
    total++; if (out_data !== C_DW'(1)) begin bad++; $display("FAIL flush_data_hold got=%0h exp=1", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0 || out_data === C_DW'(8'hD)) begin bad++; $display("FAIL flush_no_d got=%b/%0h exp=0/not d", out_valid, out_data); end
    end
  endtask

  task automatic test_bubble_mask();
    out_ready = 1'b1; in_valid = 1'b1; in_data = C_DW'(8'h55); in_ctrl = 4'hF;
    tick();
    total++; if (out_valid !== 1'b1 || out_ctrl !== 4'hF) begin bad++; $display("FAIL bubble_pre got=%b/%h exp=1/f", out_valid, out_ctrl); end
    in_valid = 1'b0; in_ctrl = 4'hF;
    tick();
    total++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin bad++; $display("FAIL bubble_mask got=%b/%h exp=0/0", out_valid, out_ctrl); end
    total++; if (out_data !== C_DW'(8'h55)) begin bad++; $display("FAIL bubble_data got=%0h exp=55", out_data); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = C_DW'(7); in_ctrl = 4'h7; tick();
    in_data = C_DW'(8); in_ctrl = 4'h8; tick();
    reset_n = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", in_ready); end
    tick();
    reset_n = 1'b1;
    total++; if (occupancy !== 2'd0 || out_data !== '0 || out_ctrl !== 4'h0) begin bad++; $display("FAIL midrst_state got=%0d/%0h/%h exp=0/0/0", occupancy, out_data, out_ctrl); end
  endtask

  task automatic test_random();
    entry_t q[$];
    logic   m_acc, m_drain;
    entry_t e;
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = {5'($urandom), $urandom, $urandom};
      in_ctrl   = 4'($urandom);
      m_acc   = in_valid && (q.size() < 2) && !flush;
      m_drain = (q.size() > 0) && out_ready;
      e.d = in_data; e.c = in_ctrl;
      tick();
      if (flush) q.delete();
      else begin
        if (m_drain) void'(q.pop_front());
        if (m_acc) q.push_back(e);
      end
      total++;
      if (out_valid !== (q.size() > 0) || occupancy !== 2'(q.size()) || in_ready !== (q.size() < 2)) begin
        bad++; $display("FAIL rnd_state[%0d] got=%b/%0d/%b exp_occ=%0d", cyc, out_valid, occupancy, in_ready, q.size());
      end
      if (q.size() > 0) begin
        total++;
        if (out_data !== q[0].d || out_ctrl !== q[0].c) begin
          bad++; $display("FAIL rnd_data[%0d] got=%0h/%h exp=%0h/%h", cyc, out_data, out_ctrl, q[0].d, q[0].c);
        end
      end else begin
        total++;
        if (out_ctrl !== 4'h0) begin bad++; $display("FAIL rnd_mask[%0d] got=%h exp=0", cyc, out_ctrl); end
      end
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush_full();
    test_bubble_mask();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
